// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register for a five-stage MIPS pipeline.
// Single-outstanding imem handshake; redirects issued during an in-flight request are deferred.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcSrc,
  input  logic        jORb,
  input  logic        pcWrite,
  input  logic        ifidWrite,
  input  logic        ifidFlush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_INS,
  output logic [31:0] ID_PC4,
  output logic        ID_valid
);

  typedef enum logic {StFetch, StHold} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_hbuf, w_hbuf_nxt;
  logic        r_kill, w_kill_nxt;
  logic [31:0] r_ptgt, w_ptgt_nxt;
  logic [31:0] r_id_ins, w_id_ins_nxt;
  logic [31:0] r_id_pc4, w_id_pc4_nxt;
  logic        r_id_valid, w_id_valid_nxt;

  logic [31:0] w_pc4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_target;
  logic        w_adv;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_tgt = r_id_pc4 + {{14{r_id_ins[15]}}, r_id_ins[15:0], 2'b00};
  assign w_j_tgt  = {r_id_pc4[31:28], r_id_ins[25:0], 2'b00};
  assign w_target = jORb ? w_br_tgt : w_j_tgt;
  assign w_adv    = pcWrite & ifidWrite;

  // Request is forced low combinationally while reset is held.
  assign imem_req  = (r_state == StFetch) & rst;
  assign imem_addr = r_pc;
  assign ID_INS    = r_id_ins;
  assign ID_PC4    = r_id_pc4;
  assign ID_valid  = r_id_valid;

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_hbuf_nxt     = r_hbuf;
    w_kill_nxt     = r_kill;
    w_ptgt_nxt     = r_ptgt;
    w_id_ins_nxt   = r_id_ins;
    w_id_pc4_nxt   = r_id_pc4;
    w_id_valid_nxt = r_id_valid;

    unique case (r_state)
      StFetch: begin
        if (imem_ack) begin
          if (r_kill || pcSrc) begin
            w_pc_nxt   = pcSrc ? w_target : r_ptgt;
            w_kill_nxt = 1'b0;
          end else if (ifidFlush) begin
            // Word dropped; PC held so the same address is refetched.
            w_pc_nxt = r_pc;
          end else if (w_adv) begin
            w_id_ins_nxt   = imem_rdata;
            w_id_pc4_nxt   = w_pc4;
            w_id_valid_nxt = 1'b1;
            w_pc_nxt       = w_pc4;
          end else begin
            w_hbuf_nxt  = imem_rdata;
            w_state_nxt = StHold;
          end
        end else if (pcSrc) begin
          // Address must stay stable for the in-flight request; apply target after its ack.
          w_kill_nxt = 1'b1;
          w_ptgt_nxt = w_target;
        end
      end
      StHold: begin
        if (pcSrc) begin
          w_pc_nxt    = w_target;
          w_state_nxt = StFetch;
        end else if (ifidFlush) begin
          w_state_nxt = StFetch;
        end else if (w_adv) begin
          w_id_ins_nxt   = r_hbuf;
          w_id_pc4_nxt   = w_pc4;
          w_id_valid_nxt = 1'b1;
          w_pc_nxt       = w_pc4;
          w_state_nxt    = StFetch;
        end
      end
      default: w_state_nxt = StFetch;
    endcase

    if (ifidFlush) begin
      w_id_ins_nxt   = 32'h0;
      w_id_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StFetch;
      r_pc       <= RESET_PC;
      r_hbuf     <= 32'h0;
      r_kill     <= 1'b0;
      r_ptgt     <= 32'h0;
      r_id_ins   <= 32'h0;
      r_id_pc4   <= 32'h0;
      r_id_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_hbuf     <= w_hbuf_nxt;
      r_kill     <= w_kill_nxt;
      r_ptgt     <= w_ptgt_nxt;
      r_id_ins   <= w_id_ins_nxt;
      r_id_pc4   <= w_id_pc4_nxt;
      r_id_valid <= w_id_valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcSrc, jORb, pcWrite, ifidWrite, ifidFlush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ID_INS, ID_PC4;
  logic        ID_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .pcSrc     (pcSrc),
    .jORb      (jORb),
    .pcWrite   (pcWrite),
    .ifidWrite (ifidWrite),
    .ifidFlush (ifidFlush),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .ID_INS    (ID_INS),
    .ID_PC4    (ID_PC4),
    .ID_valid  (ID_valid)
  );

  typedef struct {
    logic        ps, jb, pw, iw, fl, ak;
    logic [31:0] rd;
    logic        ereq;
    logic [31:0] eaddr, eins, epc4;
    logic        evalid;
  } vec_t;

  vec_t tbl [11];

  function automatic vec_t mk(input logic ps, jb, pw, iw, fl, ak, input logic [31:0] rd,
                              input logic ereq, input logic [31:0] eaddr, eins, epc4,
                              input logic evalid);
    vec_t v;
    v.ps = ps; v.jb = jb; v.pw = pw; v.iw = iw; v.fl = fl; v.ak = ak; v.rd = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.eins = eins; v.epc4 = epc4; v.evalid = evalid;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] ins, input logic [31:0] pc4, input logic valid);
    check({tag, ".req"},   {31'h0, imem_req}, {31'h0, req});
    check({tag, ".addr"},  imem_addr, addr);
    check({tag, ".ins"},   ID_INS, ins);
    check({tag, ".pc4"},   ID_PC4, pc4);
    check({tag, ".valid"}, {31'h0, ID_valid}, {31'h0, valid});
  endtask

  task automatic drive(input logic ps, jb, pw, iw, fl, ak, input logic [31:0] rd);
    pcSrc = ps; jORb = jb; pcWrite = pw; ifidWrite = iw; ifidFlush = fl;
    imem_ack = ak; imem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle, released on a falling clock edge.
  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Behavioural model: "avail" = a fetched word is in hand this cycle.
  logic [31:0] m_pc, m_hbuf, m_ptgt, m_ins, m_pc4;
  logic        m_hold, m_kill, m_valid;

  task automatic model_reset();
    m_pc = 32'h0; m_hbuf = 32'h0; m_ptgt = 32'h0; m_ins = 32'h0; m_pc4 = 32'h0;
    m_hold = 1'b0; m_kill = 1'b0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic ps, jb, pw, iw, fl, ak, input logic [31:0] rd);
    logic [31:0] tgt, word;
    logic        got, avail;
    int          off;
    off   = int'($signed(m_ins[15:0]));
    tgt   = jb ? (m_pc4 + 32'(off * 4)) : ((m_pc4 & 32'hF000_0000) | ((m_ins & 32'h03FF_FFFF) << 2));
    got   = !m_hold && ak;
    avail = m_hold || got;
    word  = m_hold ? m_hbuf : rd;
    if (ps) begin
      if (avail) begin
        m_pc = tgt; m_hold = 1'b0; m_kill = 1'b0;
      end else begin
        m_kill = 1'b1; m_ptgt = tgt;
      end
    end else if (got && m_kill) begin
      m_pc = m_ptgt; m_kill = 1'b0;
    end else if (avail) begin
      if (fl) begin
        m_hold = 1'b0;
      end else if (pw && iw) begin
        m_ins = word; m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4; m_hold = 1'b0;
      end else begin
        m_hold = 1'b1; m_hbuf = word;
      end
    end
    if (fl) begin
      m_ins = 32'h0; m_valid = 1'b0;
    end
  endtask

  initial begin
    int lat;
    logic ps, jb, pw, iw, fl, ak;
    logic [31:0] rd;

    drive(0, 0, 0, 0, 0, 0, 32'h0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #1 check_all("reset", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 check("first_req", {31'h0, imem_req}, 32'h1);
    @(negedge clk);

    // Sequential fetch, 3-cycle stall on addr 8, taken branch, flush colliding with ack.
    tbl[0]  = mk(0,0,1,1,0,1, 32'h2000_0000, 1, 32'h04, 32'h2000_0000, 32'h04, 1);
    tbl[1]  = mk(0,0,1,1,0,1, 32'h2000_0004, 1, 32'h08, 32'h2000_0004, 32'h08, 1);
    tbl[2]  = mk(0,0,0,0,0,1, 32'h2000_0008, 0, 32'h08, 32'h2000_0004, 32'h08, 1);
    tbl[3]  = mk(0,0,0,0,0,0, 32'h0,         0, 32'h08, 32'h2000_0004, 32'h08, 1);
    tbl[4]  = mk(0,0,0,0,0,0, 32'h0,         0, 32'h08, 32'h2000_0004, 32'h08, 1);
    tbl[5]  = mk(0,0,1,1,0,0, 32'h0,         1, 32'h0C, 32'h2000_0008, 32'h0C, 1);
    tbl[6]  = mk(0,0,1,1,0,1, 32'h1000_0003, 1, 32'h10, 32'h1000_0003, 32'h10, 1);
    tbl[7]  = mk(1,1,1,1,1,1, 32'hDEAD_BEEF, 1, 32'h1C, 32'h0,         32'h10, 0);
    tbl[8]  = mk(0,0,1,1,0,1, 32'h2000_001C, 1, 32'h20, 32'h2000_001C, 32'h20, 1);
    tbl[9]  = mk(0,0,1,1,1,1, 32'h2000_0020, 1, 32'h20, 32'h0,         32'h20, 0);
    tbl[10] = mk(0,0,1,1,0,1, 32'h2000_0020, 1, 32'h24, 32'h2000_0020, 32'h24, 1);

    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].ps, tbl[i].jb, tbl[i].pw, tbl[i].iw, tbl[i].fl, tbl[i].ak, tbl[i].rd);
      step();
      check_all($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eaddr, tbl[i].eins, tbl[i].epc4,
                tbl[i].evalid);
    end

    // Jump issued during a 3-cycle wait: in-flight word must be discarded.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 1, 1, 0, 1, (k == 3) ? 32'h0800_0040 : (32'h2000_0000 | 32'(k * 4)));
      step();
    end
    check_all("jmp.setup", 1'b1, 32'h10, 32'h0800_0040, 32'h10, 1'b1);
    drive(1, 0, 1, 1, 0, 0, 32'h0);
    step();
    check_all("jmp.wait1", 1'b1, 32'h10, 32'h0800_0040, 32'h10, 1'b1);
    drive(0, 0, 1, 1, 0, 0, 32'h0);
    step();
    step();
    check("jmp.wait3.addr", imem_addr, 32'h10);
    drive(0, 0, 1, 1, 0, 1, 32'hBADB_AD00);
    step();
    check_all("jmp.ack", 1'b1, 32'h100, 32'h0800_0040, 32'h10, 1'b1);
    drive(0, 0, 1, 1, 0, 1, 32'h1234_5678);
    step();
    check_all("jmp.tgt", 1'b1, 32'h104, 32'h1234_5678, 32'h104, 1'b1);

    // Reset two cycles into a pending request, with a stray ack while held.
    drive(0, 0, 1, 1, 0, 0, 32'h0);
    step();
    step();
    rst = 1'b0;
    #1 check_all("rstwait", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 1, 1, 0, 1, 32'hFFFF_FFFF);
    @(negedge clk);
    check_all("rstwait.stray", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 1, 1, 0, 0, 32'h0);
    rst = 1'b1;
    #1 check_all("rstwait.rel", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
    drive(0, 0, 1, 1, 0, 1, 32'h2000_0000);
    step();
    check_all("rstwait.f0", 1'b1, 32'h4, 32'h2000_0000, 32'h4, 1'b1);

    // Randomized traffic against the model.
    do_reset();
    model_reset();
    @(negedge clk);
    lat = -1;
    for (int c = 0; c < 2000; c++) begin
      check_all($sformatf("rnd%0d", c), !m_hold, m_pc, m_ins, m_pc4, m_valid);
      ps = ($urandom % 8) == 0;
      jb = $urandom_range(0, 1) == 1;
      pw = ($urandom % 5) != 0;
      iw = ($urandom % 5) != 0;
      fl = ($urandom % 10) == 0;
      rd = $urandom;
      if (m_hold) begin
        ak = ($urandom % 16) == 0;
      end else begin
        if (lat < 0) lat = $urandom_range(0, 3);
        ak = (lat == 0);
        lat = ak ? -1 : lat - 1;
      end
      drive(ps, jb, pw, iw, fl, ak, rd);
      model_step(ps, jb, pw, iw, fl, ak, rd);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
